time_adjust_ctrl: RTL and testbench

//  Edit sequencer between the key controller and the running time/date counter.
//  On START it snapshots the counter into shadow registers; INC/DEC pulses step the field selected by FIELD with wrap.

---
 rtl/time_adjust_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_time_adjust_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: edit sequencer between the key controller and the running
// time/date counter.
//
// On start the live counter value is snapshotted into shadow registers
// (adj_*). inc/dec pulses step the field chosen by field, with modular wrap.
// commit writes the shadow back through a one-cycle load strobe; abort
// discards it. A blink phase is generated for the digit being edited.
//
// Parameters:
//   BLINK_DIV  clk cycles per blink_on half-period (>= 2)
//   YEAR_MAX   largest year value; years run 0..YEAR_MAX
//
// Ports:
//   clk, resetn              clock; synchronous active-low reset
//   start, commit, abort     edit control pulses
//   field                    1 hour, 2 min, 3 sec, 4 meridian, 5 year, 6 month, 7 day, 0 none
//   inc, dec                 step pulses for the selected field
//   cur_*                    live counter value
//   adj_*                    shadow value presented to the counter
//   load                     one-cycle strobe: counter latches adj_*
//   busy                     high whenever not idle
//   blink_on                 blink phase for the selected digit
//
// Build option: define LEAP_YEAR_EN to give February 29 days when
// adj_year[1:0] == 0. Without it February always has 28 days.

module time_adjust_ctrl #(
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned YEAR_MAX  = 99
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       commit,
    input  logic       abort,
    input  logic [2:0] field,
    input  logic       inc,
    input  logic       dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [6:0] cur_year,
    input  logic [3:0] cur_month,
    input  logic [4:0] cur_day,
    output logic [4:0] adj_hour,
    output logic [5:0] adj_min,
    output logic [5:0] adj_sec,
    output logic [6:0] adj_year,
    output logic [3:0] adj_month,
    output logic [4:0] adj_day,
    output logic       load,
    output logic       busy,
    output logic       blink_on
);

    localparam int unsigned CntW   = $clog2(BLINK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);
    localparam logic [6:0] YearMax = 7'(YEAR_MAX);

    typedef enum logic [1:0] {StIdle, StEdit, StClamp, StWrite} state_e;

    state_e state_q, state_d;

    logic [4:0] hour_q, hour_d, day_q, day_d;
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic [6:0] year_q, year_d;
    logic [3:0] month_q, month_d;

    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;

    logic       leap;
    logic [4:0] max_day;
    logic       step;
    logic       up;

    function automatic logic [4:0] days_in(input logic [3:0] month, input logic is_leap);
        case (month)
            4'd2:                      days_in = is_leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   days_in = 5'd30;
            default:                   days_in = 5'd31;
        endcase
    endfunction

`ifdef LEAP_YEAR_EN
    assign leap = (year_q[1:0] == 2'b00);
`else
    assign leap = 1'b0;
`endif

    assign max_day = days_in(month_q, leap);
    // Exactly one of inc/dec: both together is a no-op.
    assign step    = inc ^ dec;
    assign up      = inc;

    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        blink_cnt_d = '0;
        blink_d     = 1'b1;

        case (state_q)
            StIdle: begin
                if (start) begin
                    hour_d  = cur_hour;
                    min_d   = cur_min;
                    sec_d   = cur_sec;
                    year_d  = cur_year;
                    month_d = cur_month;
                    day_d   = cur_day;
                    state_d = StEdit;
                end
            end
            StEdit: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (commit) begin
                    state_d = StWrite;
                end else if (step) begin
                    case (field)
                        3'd1: hour_d = up ? ((hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1)
                                          : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
                        3'd2: min_d  = up ? ((min_q >= 6'd59) ? 6'd0 : min_q + 6'd1)
                                          : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                        3'd3: sec_d  = up ? ((sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1)
                                          : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                        3'd4: hour_d = (hour_q < 5'd12) ? hour_q + 5'd12 : hour_q - 5'd12;
                        3'd5: begin
                            year_d  = up ? ((year_q >= YearMax) ? 7'd0 : year_q + 7'd1)
                                         : ((year_q == 7'd0) ? YearMax : year_q - 7'd1);
                            state_d = StClamp;
                        end
                        3'd6: begin
                            month_d = up ? ((month_q >= 4'd12) ? 4'd1 : month_q + 4'd1)
                                         : ((month_q <= 4'd1) ? 4'd12 : month_q - 4'd1);
                            state_d = StClamp;
                        end
                        3'd7: day_d  = up ? ((day_q >= max_day) ? 5'd1 : day_q + 5'd1)
                                          : ((day_q <= 5'd1) ? max_day : day_q - 5'd1);
                        default: ;
                    endcase
                end
            end
            StClamp: begin
                // Month/year change may leave the day past the end of the new month.
                if (day_q > max_day) begin
                    day_d = max_day;
                end
                state_d = StEdit;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Blink runs only while staying inside EDIT/CLAMP; any step restarts
        // the phase visible so the digit never vanishes while being changed.
        if ((state_q == StEdit || state_q == StClamp) &&
            (state_d == StEdit || state_d == StClamp)) begin
            if (state_q == StEdit && (inc || dec)) begin
                blink_cnt_d = '0;
                blink_d     = 1'b1;
            end else if (blink_cnt_q == CntMax) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            year_q      <= 7'd0;
            month_q     <= 4'd1;
            day_q       <= 5'd1;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign adj_hour  = hour_q;
    assign adj_min   = min_q;
    assign adj_sec   = sec_q;
    assign adj_year  = year_q;
    assign adj_month = month_q;
    assign adj_day   = day_q;
    assign load      = (state_q == StWrite);
    assign busy      = (state_q != StIdle);
    assign blink_on  = blink_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Scoreboard bench for time_adjust_ctrl: the driver pushes hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor pops
// and compares them against the DUT outputs.

module tb_time_adjust_ctrl;

    logic       clk = 1'b0;
    logic       resetn, start, commit, abort, inc, dec;
    logic [2:0] field;
    logic [4:0] cur_hour, cur_day, adj_hour, adj_day;
    logic [5:0] cur_min, cur_sec, adj_min, adj_sec;
    logic [6:0] cur_year, adj_year;
    logic [3:0] cur_month, adj_month;
    logic       load, busy, blink_on;

    always #5 clk = ~clk;

    time_adjust_ctrl #(
        .BLINK_DIV (4),
        .YEAR_MAX  (99)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .commit    (commit),
        .abort     (abort),
        .field     (field),
        .inc       (inc),
        .dec       (dec),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .cur_year  (cur_year),
        .cur_month (cur_month),
        .cur_day   (cur_day),
        .adj_hour  (adj_hour),
        .adj_min   (adj_min),
        .adj_sec   (adj_sec),
        .adj_year  (adj_year),
        .adj_month (adj_month),
        .adj_day   (adj_day),
        .load      (load),
        .busy      (busy),
        .blink_on  (blink_on)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  h;
        logic [5:0]  mi;
        logic [5:0]  s;
        logic [6:0]  y;
        logic [3:0]  mo;
        logic [4:0]  d;
        logic        busy;
        logic        load;
        logic        chk_blink;
        logic        blink;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [4:0] e_h, e_d;
    logic [5:0] e_mi, e_s;
    logic [6:0] e_y;
    logic [3:0] e_mo;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due by this cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        string       nm;
        logic [35:0] act, req;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            nm  = sb_name.pop_front();
            act = {adj_hour, adj_min, adj_sec, adj_year, adj_month, adj_day, busy, load,
                   e.chk_blink ? blink_on : 1'b0};
            req = {e.h, e.mi, e.s, e.y, e.mo, e.d, e.busy, e.load,
                   e.chk_blink ? e.blink : 1'b0};
            n_tests++;
            if (e.cyc != cyc || act !== req) begin
                n_fail++;
                $display("FAIL %s: got h%0d m%0d s%0d y%0d mo%0d d%0d busy%b load%b blink%b, want h%0d m%0d s%0d y%0d mo%0d d%0d busy%b load%b blink%b%s",
                         nm, adj_hour, adj_min, adj_sec, adj_year, adj_month, adj_day,
                         busy, load, blink_on, e.h, e.mi, e.s, e.y, e.mo, e.d, e.busy,
                         e.load, e.chk_blink ? e.blink : 1'bx,
                         (e.cyc != cyc) ? " (late)" : "");
            end
        end
    end

    task automatic set_exp(input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
                           input logic [6:0] y, input logic [3:0] mo, input logic [4:0] d);
        e_h = h; e_mi = mi; e_s = s; e_y = y; e_mo = mo; e_d = d;
    endtask

    task automatic push(input string name, input logic b_busy, input logic b_load,
                        input logic chk_b, input logic b_blink);
        exp_t e;
        e.cyc = cyc; e.h = e_h; e.mi = e_mi; e.s = e_s; e.y = e_y; e.mo = e_mo; e.d = e_d;
        e.busy = b_busy; e.load = b_load; e.chk_blink = chk_b; e.blink = b_blink;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    task automatic set_cur(input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
                           input logic [6:0] y, input logic [3:0] mo, input logic [4:0] d);
        cur_hour = h; cur_min = mi; cur_sec = s; cur_year = y; cur_month = mo; cur_day = d;
    endtask

    // One clock edge, then drop all pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0; commit = 1'b0; abort = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    logic [4:0] feb_days;

    initial begin
`ifdef LEAP_YEAR_EN
        feb_days = 5'd29;
`else
        feb_days = 5'd28;
`endif
        resetn = 1'b0; start = 1'b0; commit = 1'b0; abort = 1'b0;
        inc = 1'b0; dec = 1'b0; field = 3'd0;
        set_cur(5'd0, 6'd0, 6'd0, 7'd0, 4'd1, 5'd1);

        tick(); tick();
        set_exp(5'd0, 6'd0, 6'd0, 7'd0, 4'd1, 5'd1);
        push("reset", 1'b0, 1'b0, 1'b1, 1'b1);

        resetn = 1'b1;
        set_cur(5'd23, 6'd59, 6'd59, 7'd99, 4'd12, 5'd31);
        start = 1'b1; tick();
        set_exp(5'd23, 6'd59, 6'd59, 7'd99, 4'd12, 5'd31);
        push("start_snapshot", 1'b1, 1'b0, 1'b1, 1'b1);

        field = 3'd1; inc = 1'b1; tick(); e_h = 5'd0;  push("hour_inc_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd2; inc = 1'b1; tick(); e_mi = 6'd0; push("min_inc_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        dec = 1'b1; tick(); e_mi = 6'd59;              push("min_dec_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd7; inc = 1'b1; tick(); e_d = 5'd1;  push("day_inc_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        dec = 1'b1; tick(); e_d = 5'd31;               push("day_dec_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd3; inc = 1'b1; tick(); e_s = 6'd0;  push("sec_inc_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd5; inc = 1'b1; tick(); e_y = 7'd0;  push("year_inc_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();                                        push("year_clamp_noop", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd6; inc = 1'b1; tick(); e_mo = 4'd1; push("month_inc_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();                                        push("month_clamp_jan", 1'b1, 1'b0, 1'b0, 1'b0);
        inc = 1'b1; tick(); e_mo = 4'd2;               push("feb_preclamp", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); e_d = feb_days;                        push("feb_clamp_y00", 1'b1, 1'b0, 1'b0, 1'b0);

        abort = 1'b1; tick();                          push("abort_idle", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();                                        push("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        set_cur(5'd9, 6'd30, 6'd0, 7'd24, 4'd3, 5'd31);
        start = 1'b1; tick();
        set_exp(5'd9, 6'd30, 6'd0, 7'd24, 4'd3, 5'd31);
        push("start2", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd6; inc = 1'b1; tick(); e_mo = 4'd4; push("mar_to_apr", 1'b1, 1'b0, 1'b0, 1'b0);
        inc = 1'b1; tick(); e_d = 5'd30;               push("apr_clamp_30", 1'b1, 1'b0, 1'b0, 1'b0);
        dec = 1'b1; tick(); e_mo = 4'd3;               push("apr_to_mar", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();                                        push("mar_keep_30", 1'b1, 1'b0, 1'b0, 1'b0);
        dec = 1'b1; tick(); e_mo = 4'd2;               push("mar_to_feb", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); e_d = feb_days;                        push("feb_clamp_y24", 1'b1, 1'b0, 1'b0, 1'b0);

        field = 3'd1; inc = 1'b1; dec = 1'b1; tick();  push("inc_dec_both", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd0; inc = 1'b1; tick();              push("field0_inc", 1'b1, 1'b0, 1'b0, 1'b0);

        field = 3'd4; inc = 1'b1; tick(); e_h = 5'd21; push("meridian_inc", 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            push("blink_phase", 1'b1, 1'b0, 1'b1, (i >= 4 && i < 8) ? 1'b0 : 1'b1);
        end
        dec = 1'b1; tick(); e_h = 5'd9;                push("meridian_dec", 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) tick();                             push("blink_low", 1'b1, 1'b0, 1'b1, 1'b0);
        inc = 1'b1; tick(); e_h = 5'd21;               push("inc_forces_blink", 1'b1, 1'b0, 1'b1, 1'b1);

        commit = 1'b1; abort = 1'b1; tick();           push("abort_over_commit", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();                                        push("no_load_after_abort", 1'b0, 1'b0, 1'b0, 1'b0);

        start = 1'b1; tick();
        set_exp(5'd9, 6'd30, 6'd0, 7'd24, 4'd3, 5'd31);
        push("start3", 1'b1, 1'b0, 1'b0, 1'b0);
        commit = 1'b1; tick();                         push("write_load", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();                                        push("idle_after_write", 1'b0, 1'b0, 1'b0, 1'b0);

        start = 1'b1; tick();                          push("start4", 1'b1, 1'b0, 1'b0, 1'b0);
        field = 3'd1; inc = 1'b1; tick(); e_h = 5'd10; push("hour_inc", 1'b1, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0; tick();
        set_exp(5'd0, 6'd0, 6'd0, 7'd0, 4'd1, 5'd1);
        push("reset_mid_edit", 1'b0, 1'b0, 1'b1, 1'b1);
        resetn = 1'b1; tick();                         push("after_reset", 1'b0, 1'b0, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
